operand_loader: RTL and testbench

Sequencing master that drives `reg_rst_load` operand registers in the matrix-multiply cores. On `start` it reads a DIM×DIM matrix tile from a synchronous data RAM in row-major order. For each element it presents the word on `data_out` with a one-cycle `load_enable` strobe and a destination (row, column) index, then signals completion. It is the producer side of the `data_in`/`load_enable` interface.

---
 rtl/operand_loader.sv | 122 ++++++++++++
 tb/tb_operand_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - reads a DIMxDIM tile from a synchronous RAM
// and strobes each element, row-major, into the operand registers.
module operand_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DIM        = 4,
  localparam int IDX_W     = $clog2(DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  load_enable,
  output logic [IDX_W-1:0]      load_row,
  output logic [IDX_W-1:0]      load_col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   row_base;
  logic [ADDR_WIDTH-1:0]   stride;
  logic [IDX_W-1:0]        rd_row, rd_col;
  logic [IDX_W-1:0]        s1_row, s1_col;
  logic                    s1_valid;
  logic                    rd_last;
  logic                    tile_loaded;

  assign rd_last     = (rd_row == LAST_IDX) && (rd_col == LAST_IDX);
  assign tile_loaded = load_enable && (load_row == LAST_IDX) && (load_col == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_READ;
      S_READ: begin
        busy = 1'b1;
        if (rd_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tile_loaded) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Read issue: rd_row/rd_col always name the element whose address is on mem_addr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      row_base  <= '0;
      stride    <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
    end else if (state == S_IDLE && start) begin
      mem_addr  <= base_addr;
      row_base  <= base_addr;
      stride    <= row_stride;
      rd_row    <= '0;
      rd_col    <= '0;
      mem_rd_en <= 1'b1;
    end else if (state == S_READ) begin
      if (rd_last) begin
        mem_rd_en <= 1'b0;
      end else if (rd_col != LAST_IDX) begin
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
        rd_col   <= rd_col + IDX_W'(1);
      end else begin
        row_base <= row_base + stride;
        mem_addr <= row_base + stride;
        rd_col   <= '0;
        rd_row   <= rd_row + IDX_W'(1);
      end
    end
  end

  // Two-stage return path; data_out and indices hold between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_row      <= '0;
      s1_col      <= '0;
      data_out    <= '0;
      load_enable <= 1'b0;
      load_row    <= '0;
      load_col    <= '0;
    end else begin
      s1_valid    <= mem_rd_en;
      s1_row      <= rd_row;
      s1_col      <= rd_col;
      load_enable <= s1_valid;
      if (s1_valid) begin
        data_out <= mem_rdata;
        load_row <= s1_row;
        load_col <= s1_col;
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - self-checking bench for operand_loader
module tb_operand_loader;
  localparam int N = 48;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  row_stride = '0;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic [15:0] data_out;
  logic        load_enable;
  logic [1:0]  load_row;
  logic [1:0]  load_col;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ram [256];
  logic        exp_rd [N];
  logic        exp_le [N];
  logic        exp_busy [N];
  logic        exp_done [N];
  logic [7:0]  exp_addr [N];
  logic [15:0] exp_data [N];
  logic [3:0]  exp_rc [N];
  logic [31:0] exp_vec [N];
  logic [31:0] obs_vec [N];
  logic [15:0] model_last = '0;

  operand_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .row_stride(row_stride), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .data_out(data_out), .load_enable(load_enable),
    .load_row(load_row), .load_col(load_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) ram[i] = 16'(100 + i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      exp_rd[k] = 0; exp_le[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
      exp_addr[k] = '0; exp_data[k] = '0; exp_rc[k] = '0;
    end
  endtask

  // Element j of a tile accepted at edge ts is read in cycle ts+1+j, loaded in ts+3+j.
  task automatic model_tile(input logic [7:0] b, input logic [7:0] s, input int ts);
    for (int j = 0; j < T; j++) begin
      int r = j / 4;
      int c = j % 4;
      logic [7:0] a = 8'(int'(b) + r * int'(s) + c);
      exp_rd[ts+1+j]   = 1'b1;
      exp_addr[ts+1+j] = a;
      exp_le[ts+3+j]   = 1'b1;
      exp_data[ts+3+j] = ram[a];
      exp_rc[ts+3+j]   = {2'(r), 2'(c)};
    end
    for (int k = ts + 1; k <= ts + T + 2; k++) exp_busy[k] = 1'b1;
    exp_done[ts+T+3] = 1'b1;
  endtask

  task automatic model_finalize(input int n);
    logic [15:0] cur = model_last;
    for (int k = 0; k < n; k++) begin
      if (exp_le[k]) cur = exp_data[k];
      else exp_data[k] = cur;
      exp_vec[k] = {exp_rd[k], exp_le[k], exp_busy[k], exp_done[k],
                    exp_rd[k] ? exp_addr[k] : 8'h00, exp_data[k],
                    exp_le[k] ? exp_rc[k] : 4'h0};
    end
    model_last = cur;
  endtask

  // Drives start per mask bit (bit k = start high during cycle k) and records outputs.
  task automatic capture(input logic [7:0] b, input logic [7:0] s, input logic [47:0] mask, input int n);
    @(negedge clk);
    base_addr  = b;
    row_stride = s;
    for (int k = 0; k < n; k++) begin
      start = mask[k];
      obs_vec[k] = {mem_rd_en, load_enable, busy, done, mem_rd_en ? mem_addr : 8'h00,
                    data_out, load_enable ? {load_row, load_col} : 4'h0};
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] v;
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    v = {mem_addr, mem_rd_en, data_out, load_enable, load_row, load_col, busy, done};
    n_cmp++;
    if (v !== '0) begin n_err++; $display("FAIL reset_hold: got %h want 0", v); end
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    v = {mem_addr, mem_rd_en, data_out, load_enable, load_row, load_col, busy, done};
    n_cmp++;
    if (v !== '0) begin n_err++; $display("FAIL reset_release: got %h want 0", v); end
    model_last = '0;
  endtask

  task automatic test_basic();
    int cnt = 0;
    fill_linear();
    model_clear();
    model_tile(8'h10, 8'd4, 0);
    model_finalize(26);
    capture(8'h10, 8'd4, 48'h1, 26);
    for (int k = 0; k < 26; k++) begin
      n_cmp++;
      if (obs_vec[k] !== exp_vec[k]) begin
        n_err++; $display("FAIL basic c%0d: got %h want %h", k, obs_vec[k], exp_vec[k]);
      end
      if (obs_vec[k][30]) cnt++;
    end
    n_cmp++;
    if (cnt != 16) begin n_err++; $display("FAIL basic_strobes: got %0d want 16", cnt); end
    n_cmp++;
    if (obs_vec[3][19:4] !== 16'd116 || obs_vec[18][19:4] !== 16'd131) begin
      n_err++; $display("FAIL basic_ends: got %0d..%0d want 116..131", obs_vec[3][19:4], obs_vec[18][19:4]);
    end
    n_cmp++;
    if (obs_vec[19][28] !== 1'b1) begin n_err++; $display("FAIL basic_done19: got %b want 1", obs_vec[19][28]); end
  endtask

  task automatic test_hold();
    for (int k = 19; k < 26; k++) begin
      n_cmp++;
      if (obs_vec[k][19:4] !== 16'd131 || obs_vec[k][30] !== 1'b0 || obs_vec[k][29] !== 1'b0) begin
        n_err++; $display("FAIL hold c%0d: got data=%0d le=%b busy=%b want 131 0 0",
                          k, obs_vec[k][19:4], obs_vec[k][30], obs_vec[k][29]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] bases [4];
    bases[0] = 8'hF8; bases[1] = 8'h00; bases[2] = 8'h08; bases[3] = 8'h10;
    model_clear();
    model_tile(8'hF8, 8'd8, 0);
    model_finalize(22);
    capture(8'hF8, 8'd8, 48'h1, 22);
    for (int k = 0; k < 22; k++) begin
      n_cmp++;
      if (obs_vec[k] !== exp_vec[k]) begin
        n_err++; $display("FAIL wrap c%0d: got %h want %h", k, obs_vec[k], exp_vec[k]);
      end
    end
    for (int r = 0; r < 4; r++) begin
      n_cmp++;
      if (obs_vec[1+4*r][27:20] !== bases[r]) begin
        n_err++; $display("FAIL wrap_rowbase r%0d: got %h want %h", r, obs_vec[1+4*r][27:20], bases[r]);
      end
    end
    n_cmp++;
    if (obs_vec[7][27:20] !== 8'h02) begin
      n_err++; $display("FAIL wrap_elem12: got %h want 02", obs_vec[7][27:20]);
    end
  endtask

  task automatic test_start_busy();
    int strobes = 0;
    int dones = 0;
    int first = -1;
    fill_linear();
    model_clear();
    model_tile(8'h10, 8'd4, 0);
    model_tile(8'h10, 8'd4, 20);
    model_finalize(44);
    capture(8'h10, 8'd4, (48'h1 | (48'h1 << 5) | (48'h1 << 19) | (48'h1 << 20)), 44);
    for (int k = 0; k < 44; k++) begin
      n_cmp++;
      if (obs_vec[k] !== exp_vec[k]) begin
        n_err++; $display("FAIL start_busy c%0d: got %h want %h", k, obs_vec[k], exp_vec[k]);
      end
      if (k < 20 && obs_vec[k][30]) strobes++;
      if (k < 20 && obs_vec[k][28]) dones++;
      if (k >= 20 && first < 0 && obs_vec[k][30]) first = k;
    end
    n_cmp++;
    if (strobes != 16 || dones != 1) begin
      n_err++; $display("FAIL start_busy_counts: got %0d strobes %0d done want 16 1", strobes, dones);
    end
    n_cmp++;
    if (first != 23) begin n_err++; $display("FAIL start_busy_second: got first strobe %0d want 23", first); end
  endtask

  task automatic test_zero_stride();
    model_clear();
    model_tile(8'h20, 8'd0, 0);
    model_finalize(22);
    capture(8'h20, 8'd0, 48'h1, 22);
    for (int k = 0; k < 22; k++) begin
      n_cmp++;
      if (obs_vec[k] !== exp_vec[k]) begin
        n_err++; $display("FAIL zero_stride c%0d: got %h want %h", k, obs_vec[k], exp_vec[k]);
      end
    end
    n_cmp++;
    if (obs_vec[15][3:2] !== 2'd3 || obs_vec[15][19:4] !== ram[8'h20]) begin
      n_err++; $display("FAIL zero_stride_row3: got row=%0d data=%h want 3 %h", obs_vec[15][3:2], obs_vec[15][19:4], ram[8'h20]);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] v;
    int bad = 0;
    @(negedge clk);
    base_addr = 8'h10; row_stride = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 reset = 1'b0;
    #1 v = {mem_addr, mem_rd_en, data_out, load_enable, load_row, load_col, busy, done};
    n_cmp++;
    if (v !== '0) begin n_err++; $display("FAIL reset_mid_async: got %h want 0", v); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v = {mem_addr, mem_rd_en, data_out, load_enable, load_row, load_col, busy, done};
      n_cmp++;
      if (v !== '0) begin n_err++; $display("FAIL reset_mid_low c%0d: got %h want 0", k, v); end
    end
    reset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (load_enable || done || busy) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", bad); end
    model_last = '0;
    model_clear();
    model_tile(8'h30, 8'd5, 0);
    model_finalize(22);
    capture(8'h30, 8'd5, 48'h1, 22);
    for (int k = 0; k < 22; k++) begin
      n_cmp++;
      if (obs_vec[k] !== exp_vec[k]) begin
        n_err++; $display("FAIL reset_mid_retile c%0d: got %h want %h", k, obs_vec[k], exp_vec[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      logic [7:0] b = 8'($urandom);
      logic [7:0] s = 8'($urandom);
      fill_random();
      model_clear();
      model_tile(b, s, 0);
      model_finalize(22);
      capture(b, s, 48'h1, 22);
      for (int k = 0; k < 22; k++) begin
        n_cmp++;
        if (obs_vec[k] !== exp_vec[k]) begin
          n_err++; $display("FAIL random t%0d c%0d: got %h want %h", t, k, obs_vec[k], exp_vec[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wrap();
    test_start_busy();
    test_zero_stride();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
